// File: rtl/ntru_hrss_pkg.sv
// Shared NTRU-HRSS constants, FSM state encoding and coefficient type
// for the public-key byte unpacking path.
package ntru_hrss_pkg;

    localparam int COEF_BITS  = 13;
    localparam int N_PAIRS    = 350;
    localparam int N_BYTES    = 1138;

    // Two coefficients per transfer; the buffer holds one pair plus a partial byte
    localparam int PAIR_BITS  = 2 * COEF_BITS;
    localparam int BUF_BITS   = 34;
    localparam int CNT_BITS   = 6;
    localparam int BYTE_CNT_W = 11;
    localparam int PAIR_CNT_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [COEF_BITS-1:0] coef_t;

endpackage

// File: rtl/rq0_bit_buffer.sv
// 34-bit little-endian bit accumulator: pops one 26-bit pair from the bottom,
// then inserts an incoming byte at the current fill level.
module rq0_bit_buffer
    import ntru_hrss_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [7:0]           i_byte,
    output logic [PAIR_BITS-1:0] o_low,
    output logic [CNT_BITS-1:0]  o_cnt
);

    logic [BUF_BITS-1:0] r_buf;
    logic [CNT_BITS-1:0] r_cnt;
    logic [BUF_BITS-1:0] w_shifted;
    logic [BUF_BITS-1:0] w_inserted;
    logic [BUF_BITS-1:0] w_nextBuf;
    logic [CNT_BITS-1:0] w_baseCnt;
    logic [CNT_BITS-1:0] w_nextCnt;

    // The pop is applied first so a same-cycle byte lands just above the leftover bits
    always_comb begin
        w_shifted  = i_pop ? (r_buf >> PAIR_BITS) : r_buf;
        w_baseCnt  = i_pop ? (r_cnt - CNT_BITS'(PAIR_BITS)) : r_cnt;
        w_inserted = BUF_BITS'(i_byte) << w_baseCnt;
        w_nextBuf  = i_push ? (w_shifted | w_inserted) : w_shifted;
        w_nextCnt  = i_push ? (w_baseCnt + CNT_BITS'(8)) : w_baseCnt;
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            r_buf <= w_nextBuf;
            r_cnt <= w_nextCnt;
        end
    end

    assign o_low = r_buf[PAIR_BITS-1:0];
    assign o_cnt = r_cnt;

endmodule

// File: rtl/rq0_byte_unpacker.sv
// Rq0 public-key byte unpacker: 1138 packed bytes -> 350 coefficient pairs plus a LAST token.
// Optional pad-bit format check enabled by defining RQ0_PAD_CHECK_EN (adds port fmt_err).
module rq0_byte_unpacker
    import ntru_hrss_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [COEF_BITS-1:0] even,
    output logic [COEF_BITS-1:0] odd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 last_n,
    output logic                 done_n,
    output logic                 busy
`ifdef RQ0_PAD_CHECK_EN
    ,
    output logic                 fmt_err
`endif
);

    state_t                r_state;
    logic [BYTE_CNT_W-1:0] r_byteCnt;
    logic [PAIR_CNT_W-1:0] r_pairCnt;
    logic [PAIR_BITS-1:0]  w_low;
    logic [CNT_BITS-1:0]   w_bitCnt;
    logic                  w_start;
    logic                  w_pairValid;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_inReady;
    logic                  w_lastAccept;
    logic                  w_clear;

    assign w_start      = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_pairValid  = (r_state == RUN) && (w_bitCnt >= CNT_BITS'(PAIR_BITS));
    assign w_pop        = w_pairValid && out_ready;
    assign w_inReady    = (r_state == RUN) && (r_byteCnt < BYTE_CNT_W'(N_BYTES)) &&
                          ((w_bitCnt < CNT_BITS'(PAIR_BITS)) || out_ready);
    assign w_push       = in_valid && w_inReady;
    assign w_lastAccept = (r_state == LAST) && out_ready;
    // Leaving LAST drops the pad bits so DONE starts from an empty buffer
    assign w_clear      = w_start || w_lastAccept;

    rq0_bit_buffer u_bitBuffer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_byte  (in_byte),
        .o_low   (w_low),
        .o_cnt   (w_bitCnt)
    );

    // The last pop moves straight to LAST; by then every byte has been consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_byteCnt <= '0;
            r_pairCnt <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state   <= RUN;
                        r_byteCnt <= '0;
                        r_pairCnt <= '0;
                    end
                end
                RUN: begin
                    if (w_push) begin
                        r_byteCnt <= r_byteCnt + BYTE_CNT_W'(1);
                    end
                    if (w_pop) begin
                        r_pairCnt <= r_pairCnt + PAIR_CNT_W'(1);
                        if (r_pairCnt == PAIR_CNT_W'(N_PAIRS - 1)) begin
                            r_state <= LAST;
                        end
                    end
                end
                LAST: begin
                    if (out_ready) begin
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef RQ0_PAD_CHECK_EN
    logic r_fmtErr;

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_fmtErr <= 1'b0;
        end else if (w_lastAccept && (w_low[3:0] != 4'd0)) begin
            r_fmtErr <= 1'b1;
        end
    end

    assign fmt_err = r_fmtErr;
`endif

    assign in_ready  = w_inReady;
    assign out_valid = w_pairValid || (r_state == LAST);
    assign even      = (r_state == RUN) ? w_low[COEF_BITS-1:0] : '0;
    assign odd       = (r_state == RUN) ? w_low[PAIR_BITS-1:COEF_BITS] : '0;
    assign last_n    = (r_state != LAST);
    assign done_n    = (r_state != DONE);
    assign busy      = (r_state == RUN) || (r_state == LAST);

endmodule

// File: doc/rq0_byte_unpacker.md
Name: rq0_byte_unpacker

Overview:
- Stage directly upstream of the Rq0 unpacker (the accumulate/negate/shift-register stage) in the NTRU-HRSS KEM decapsulation path.
- Consumes the packed public-key byte stream: 1138 bytes holding 700 little-endian 13-bit coefficients plus 4 pad bits.
- Emits one even/odd coefficient pair per transfer.
- Generates the last_n/done_n controls that tell the downstream stage when to substitute the derived final coefficient and when to freeze.

Parameters:
- COEF_BITS, 13, bits per coefficient (log2 q).
- N_PAIRS, 350, coefficient pairs per key: (n-1)/2 with n=701.
- N_BYTES, 1138, packed input bytes: ceil(700*13/8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new key when in IDLE or DONE.
- in_byte  in  8  packed byte, LSB = lowest-numbered bit.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- even  out  COEF_BITS  coefficient 2k.
- odd  out  COEF_BITS  coefficient 2k+1.
- out_valid  out  1  pair (or last token) valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- last_n  out  1  low during the final-coefficient token.
- done_n  out  1  low once a key is complete; held until restart.
- busy  out  1  high in RUN or LAST.

Behaviour:
- Reset is synchronous: state=IDLE, bit buffer=0, bit_cnt=0, byte_cnt=0, pair_cnt=0. Outputs reset to in_ready=0, out_valid=0, even=odd=0, last_n=1, done_n=1, busy=0.
- rst mid-operation aborts immediately to the reset state. Partial data is discarded.
- FSM states are IDLE, RUN, LAST, DONE.
  - IDLE/DONE to RUN on start. This clears buffer and counters and sets done_n=1 on the same edge.
  - start is ignored in RUN and LAST.
- Bit buffer is 34 bits wide; bit_cnt is 6 bits, maximum 33. New bytes are inserted at bit position bit_cnt, after any same-cycle pop.
- out_valid in RUN is (bit_cnt >= 26); it is registered-state only.
  - even = buf[12:0], odd = buf[25:13].
  - On pop: buffer shifts right 26, bit_cnt -= 26, pair_cnt++.
- in_ready = RUN && byte_cnt < N_BYTES && (bit_cnt < 26 || out_ready).
  - This is combinational from out_ready; there is no path from in_valid to any output.
  - Simultaneous pop and push in one cycle is legal: bit_cnt = bit_cnt - 26 + 8.
- Sustained throughput is one pair per 3.25 input bytes.
- When pair_cnt reaches N_PAIRS, RUN goes to LAST. At that point byte_cnt=N_BYTES and bit_cnt=4 (the pad bits).
- LAST token:
  - out_valid=1, last_n=0, even=odd=0.
  - On acceptance go to DONE.
- DONE: out_valid=0, done_n=0, last_n=1, in_ready=0.
- Bytes presented with in_valid while in_ready=0 are not consumed. The producer must hold them.
- Pad bits are discarded on the LAST-to-DONE transition.

Optional Feature:
- Macro: RQ0_PAD_CHECK_EN.
- Defined:
  - Adds output port fmt_err (1 bit, reset 0).
  - Set sticky on the LAST-to-DONE transition if the 4 pad bits are nonzero.
  - Cleared on start or rst.
- Undefined: no port exists; pad bits are silently ignored.

Decomposition:
- Shared package ntru_hrss_pkg:
  - COEF_BITS, N_PAIRS, N_BYTES.
  - The FSM state enum typedef (IDLE, RUN, LAST, DONE).
  - Typedef coef_t (logic [COEF_BITS-1:0]).
- One natural sub-module, rq0_bit_buffer: the 34-bit buffer plus bit_cnt, with push/pop controls and the aligned insert.
- FSM and counters stay in the top module.

Test Plan:
- Pair alignment: after start, bytes 0x01,0x20,0x00,0x00 with out_ready=1 -> first pair even=0x0001, odd=0x0001, out_valid high the cycle after byte 4 is accepted (bit_cnt=32).
- Full key: 1137 bytes 0xFF then 0x0F, in_valid and out_ready always high -> exactly 350 pairs of 0x1FFF/0x1FFF, then one token with last_n=0, then done_n=0 with out_valid=0. busy falls with done_n.
- Backpressure: out_ready=0 after start, bytes streamed -> in_ready drops after the 4th byte, even/odd stay stable, no byte lost. Raising out_ready resumes with simultaneous pop+push; pair sequence is identical to the no-stall run.
- Reset mid-run: rst asserted after 200 bytes -> next cycle all outputs at reset values. A fresh start plus the full key reproduces the golden 350 pairs.
- Restart: start while in RUN is ignored (pair_cnt unaffected). start in DONE returns done_n to 1 and a second key unpacks correctly.
- RQ0_PAD_CHECK_EN: final byte 0x1F -> fmt_err=1 on entry to DONE, cleared by next start. Final byte 0x0F -> fmt_err stays 0.
